// File: rtl/barrel_shift_sequencer.sv
// barrel_shift_sequencer: round-robin sequencer sharing one registered
// 4-bit logical barrel shifter between two requesters.
//
// Splits each job (amount 0-15) into passes of at most 3, feeding the
// shifter result back as the next operand; one response per job.
//
// Ports:
//   clock, reset      rising-edge clock, async active-high reset
//   req0_*, req1_*    job handshake: valid/ready, data, amt, left
//   resp_*            result handshake: valid/ready, id, data
//   sh_sa/left/in     shifter inputs (registered here)
//   sh_out            shifter result, valid one cycle after sh_*
//
// Optional: SHIFT_SHORTCUT_EN -- jobs with amt >= 4 complete in one
// cycle with a zero result, bypassing the shifter.

module barrel_shift_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_data,
  input  logic [3:0] req0_amt,
  input  logic       req0_left,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_data,
  input  logic [3:0] req1_amt,
  input  logic       req1_left,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_id,
  output logic [3:0] resp_data,
  output logic [1:0] sh_sa,
  output logic       sh_left,
  output logic [3:0] sh_in,
  input  logic [3:0] sh_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0] state;
  logic       ptr;
  logic [3:0] work;
  logic [3:0] rem;
  logic       id;
  logic       left;

  logic       gnt0;
  logic       gnt1;
  logic       acc;
  logic [3:0] a_data;
  logic [3:0] a_amt;
  logic       a_left;
  logic [1:0] a_step;
  logic [1:0] n_step;

  function automatic logic [1:0] min3(
    input logic [3:0] x
  );
    return (x >= 4'd3) ? 2'd3 : x[1:0];
  endfunction

  // Pointer holder wins a tie; a lone requester always wins.
  always_comb begin
    gnt0   = req0_valid & (~ptr | ~req1_valid);
    gnt1   = req1_valid & (ptr | ~req0_valid);
    req0_ready = (state == IDLE) & gnt0;
    req1_ready = (state == IDLE) & gnt1;
    acc    = req0_ready | req1_ready;
    a_data = gnt1 ? req1_data : req0_data;
    a_amt  = gnt1 ? req1_amt  : req0_amt;
    a_left = gnt1 ? req1_left : req0_left;
    a_step = min3(a_amt);
    n_step = min3(rem);
  end

  assign resp_valid = (state == DONE);
  assign resp_id    = id;
  assign resp_data  = work;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      work    <= 4'd0;
      rem     <= 4'd0;
      id      <= 1'b0;
      left    <= 1'b0;
      sh_sa   <= 2'd0;
      sh_left <= 1'b0;
      sh_in   <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            id   <= gnt1;
            ptr  <= ~gnt1;
            left <= a_left;
            work <= a_data;
`ifdef SHIFT_SHORTCUT_EN
            if (a_amt >= 4'd4) begin
              work  <= 4'd0;
              rem   <= 4'd0;
              state <= DONE;
            end else begin
              rem     <= a_amt - {2'b00, a_step};
              sh_in   <= a_data;
              sh_left <= a_left;
              sh_sa   <= a_step;
              state   <= ISSUE;
            end
`else
            rem     <= a_amt - {2'b00, a_step};
            sh_in   <= a_data;
            sh_left <= a_left;
            sh_sa   <= a_step;
            state   <= ISSUE;
`endif
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          work <= sh_out;
          if (rem == 4'd0) begin
            state <= DONE;
          end else begin
            sh_in   <= sh_out;
            sh_left <= left;
            sh_sa   <= n_step;
            rem     <= rem - {2'b00, n_step};
            state   <= ISSUE;
          end
        end
        DONE: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
